alu_pipe_arbiter: RTL and testbench

- Shares one fixed-latency ALU pipeline (the add-then-subtract three-stage pipeline, with no valid and no stall) between two requesters.
- Each cycle it grants at most one requester using round-robin, and drives that requester's operands into the pipeline.
- It tracks a requester-ID tag alongside each issued operation and routes the result back to the requester that issued it.
- A drain/idle handshake lets system control empty the pipeline before reconfiguration or power-down.

---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/alu_arb_tag_shreg.sv | 44 ++++
 rtl/alu_pipe_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_pipe_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU pipeline arbiter.
// Optional grant statistics are enabled with ALU_ARB_STATS_EN.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic vld;
        logic id;
    } arb_tag_t;

    localparam int STATS_W = 16;

    // Saturating increment for the grant counters.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/alu_arb_tag_shreg.sv
// Requester-ID tag delay line travelling alongside the ALU pipeline.
// The tail entry lines up with the pipeline result of the same operation.
module alu_arb_tag_shreg
    import alu_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_i,
    input  logic id_i,
    output logic tail_vld_o,
    output logic tail_id_o
);

    arb_tag_t tag_q [DEPTH];
    arb_tag_t tag_d [DEPTH];

    // Shift every cycle; entry 0 takes this cycle's issue tag.
    always_comb begin
        tag_d[0].vld = vld_i;
        tag_d[0].id  = id_i;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag storage; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tail_vld_o = tag_q[DEPTH-1].vld;
    assign tail_id_o  = tag_q[DEPTH-1].id;

endmodule

// File: rtl/alu_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALU pipeline between two requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_pipe_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid_i,
    output logic                          req0_ready_o,
    input  logic [DWIDTH-1:0]             req0_op1_i,
    input  logic [DWIDTH-1:0]             req0_op2_i,
    input  logic                          req1_valid_i,
    output logic                          req1_ready_o,
    input  logic [DWIDTH-1:0]             req1_op1_i,
    input  logic [DWIDTH-1:0]             req1_op2_i,
    output logic [DWIDTH-1:0]             pipe_op1_o,
    output logic [DWIDTH-1:0]             pipe_op2_o,
    input  logic [DWIDTH-1:0]             pipe_res_i,
    output logic                          rsp0_valid_o,
    output logic                          rsp1_valid_o,
    output logic [DWIDTH-1:0]             rsp_data_o,
    input  logic                          drain_i,
    output logic                          idle_o,
`ifdef ALU_ARB_STATS_EN
    input  logic                          stats_clr_i,
    output logic [STATS_W-1:0]            grant_cnt0_o,
    output logic [STATS_W-1:0]            grant_cnt1_o,
`endif
    output logic [$clog2(PIPE_LAT+2)-1:0] inflight_o
);

    localparam int IW = $clog2(PIPE_LAT+2);
    localparam logic [IW-1:0] INF_MAX = IW'(PIPE_LAT + 1);

    arb_state_e        state_q, state_d;
    logic              rr_q, rr_d;
    logic [IW-1:0]     inflight_q, inflight_d;
    logic              rsp0_q, rsp0_d;
    logic              rsp1_q, rsp1_d;
    logic [DWIDTH-1:0] data_q, data_d;

    logic gnt0, gnt1, grant, can_issue;
    logic tail_vld, tail_id, rsp_pulse;

    // Round-robin grant; rr_q = 0 favours requester 0.
    always_comb begin
        can_issue = (state_q == RUN) && !drain_i && !rst;
        gnt0 = can_issue && req0_valid_i && (!req1_valid_i || !rr_q);
        gnt1 = can_issue && req1_valid_i && (!req0_valid_i || rr_q);
        grant = gnt0 | gnt1;
        rr_d = grant ? gnt0 : rr_q;
    end

    // Operand mux into the pipeline; zero bubble when nothing is granted.
    always_comb begin
        pipe_op1_o = '0;
        pipe_op2_o = '0;
        unique case (1'b1)
            gnt0: begin
                pipe_op1_o = req0_op1_i;
                pipe_op2_o = req0_op2_i;
            end
            gnt1: begin
                pipe_op1_o = req1_op1_i;
                pipe_op2_o = req1_op2_i;
            end
            default: ;
        endcase
    end

    alu_arb_tag_shreg #(
        .DEPTH (PIPE_LAT)
    ) u_tags (
        .clk        (clk),
        .rst        (rst),
        .vld_i      (grant),
        .id_i       (gnt1),
        .tail_vld_o (tail_vld),
        .tail_id_o  (tail_id)
    );

    // Route the aligned pipeline result to its owner; data holds on bubbles.
    always_comb begin
        rsp_pulse = tail_vld;
        rsp0_d = tail_vld && !tail_id;
        rsp1_d = tail_vld && tail_id;
        data_d = tail_vld ? pipe_res_i : data_q;
    end

    // In-flight count: issue adds one, registered response removes one.
    always_comb begin
        inflight_d = inflight_q;
        if (grant && !rsp_pulse) begin
            if (inflight_q != INF_MAX) begin
                inflight_d = inflight_q + IW'(1);
            end
        end else if (!grant && rsp_pulse) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - IW'(1);
            end
        end
    end

    // Drain sequencing: stop issue, wait for empty, park in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (drain_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (inflight_q == '0 && !rsp0_q && !rsp1_q) state_d = IDLE;
            end
            IDLE: begin
                if (!drain_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            rr_q       <= 1'b0;
            inflight_q <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            rsp0_q     <= rsp0_d;
            rsp1_q     <= rsp1_d;
            data_q     <= data_d;
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign rsp0_valid_o = rsp0_q;
    assign rsp1_valid_o = rsp1_q;
    assign rsp_data_o   = data_q;
    assign idle_o       = (state_q == IDLE);
    assign inflight_o   = inflight_q;

`ifdef ALU_ARB_STATS_EN
    logic [STATS_W-1:0] cnt0_q, cnt0_d;
    logic [STATS_W-1:0] cnt1_q, cnt1_d;

    // Saturating grant counters; clear wins over a coincident grant.
    always_comb begin
        cnt0_d = gnt0 ? sat_inc(cnt0_q) : cnt0_q;
        cnt1_d = gnt1 ? sat_inc(cnt1_q) : cnt1_q;
        if (stats_clr_i) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end
    end

    // Counter storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0_o = cnt0_q;
    assign grant_cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_pipe_arbiter.sv
// Self-checking bench for alu_pipe_arbiter with a transaction-level reference model.
// Grant-counter checks are included when ALU_ARB_STATS_EN is defined.
module tb_alu_pipe_arbiter;

    localparam int DW  = 8;
    localparam int LAT = 3;
    localparam int IW  = $clog2(LAT+2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic req0_ready_o, req1_ready_o;
    logic [DW-1:0] req0_op1_i = '0, req0_op2_i = '0;
    logic [DW-1:0] req1_op1_i = '0, req1_op2_i = '0;
    logic [DW-1:0] pipe_op1_o, pipe_op2_o, pipe_res_i, rsp_data_o;
    logic rsp0_valid_o, rsp1_valid_o;
    logic drain_i = 1'b0;
    logic idle_o;
    logic [IW-1:0] inflight_o;
`ifdef ALU_ARB_STATS_EN
    logic stats_clr_i = 1'b0;
    logic [15:0] grant_cnt0_o, grant_cnt1_o;
`endif

    alu_pipe_arbiter #(.DWIDTH(DW), .PIPE_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_op1_i   (req0_op1_i),
        .req0_op2_i   (req0_op2_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_op1_i   (req1_op1_i),
        .req1_op2_i   (req1_op2_i),
        .pipe_op1_o   (pipe_op1_o),
        .pipe_op2_o   (pipe_op2_o),
        .pipe_res_i   (pipe_res_i),
        .rsp0_valid_o (rsp0_valid_o),
        .rsp1_valid_o (rsp1_valid_o),
        .rsp_data_o   (rsp_data_o),
        .drain_i      (drain_i),
        .idle_o       (idle_o),
`ifdef ALU_ARB_STATS_EN
        .stats_clr_i  (stats_clr_i),
        .grant_cnt0_o (grant_cnt0_o),
        .grant_cnt1_o (grant_cnt1_o),
`endif
        .inflight_o   (inflight_o)
    );

    always #5 clk = ~clk;

    // External ALU pipeline: add, then subtract 3, three register stages.
    logic [DW-1:0] p0, p1, p2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0 <= '0;
            p1 <= '0;
            p2 <= '0;
        end else begin
            p0 <= pipe_op1_o + pipe_op2_o;
            p1 <= p0 - 8'd3;
            p2 <= p1;
        end
    end
    assign pipe_res_i = p2;

    typedef struct {
        int          id;
        logic [7:0]  data;
        int          due;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc_n = 0;
    int         ptr = 0;
    int         mode = 0;
    logic [7:0] last_data = '0;
    int         cnt0 = 0, cnt1 = 0;
    bit         g0, g1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ptr = 0;
        mode = 0;
        last_data = '0;
        cnt0 = 0;
        cnt1 = 0;
    endtask

    // One clock cycle: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit e0, e1, p;
        logic [7:0] eo1, eo2, d;
        bit ev0, ev1;
        @(negedge clk);
        e0 = 0;
        e1 = 0;
        if (mode == 0 && !drain_i) begin
            if (req0_valid_i && (!req1_valid_i || ptr == 0)) e0 = 1;
            else if (req1_valid_i) e1 = 1;
        end
        eo1 = e0 ? req0_op1_i : (e1 ? req1_op1_i : 8'h0);
        eo2 = e0 ? req0_op2_i : (e1 ? req1_op2_i : 8'h0);
        ev0 = 0;
        ev1 = 0;
        if (q.size() > 0 && q[0].due == cyc_n) begin
            ev0 = (q[0].id == 0);
            ev1 = (q[0].id == 1);
            last_data = q[0].data;
            void'(q.pop_front());
        end
        chk("ready0", req0_ready_o, e0);
        chk("ready1", req1_ready_o, e1);
        chk("pipe_op1", pipe_op1_o, eo1);
        chk("pipe_op2", pipe_op2_o, eo2);
        chk("rsp0", rsp0_valid_o, ev0);
        chk("rsp1", rsp1_valid_o, ev1);
        chk("rsp_data", rsp_data_o, last_data);
        chk("inflight", inflight_o, q.size());
        chk("idle", idle_o, mode == 2);
`ifdef ALU_ARB_STATS_EN
        chk("cnt0", grant_cnt0_o, cnt0);
        chk("cnt1", grant_cnt1_o, cnt1);
`endif
        p = ev0 | ev1;
        @(posedge clk);
        if (e0 | e1) begin
            d = eo1 + eo2 - 8'd3;
            q.push_back('{id: int'(e1), data: d, due: cyc_n + LAT + 1});
            ptr = e0 ? 1 : 0;
            if (e0) cnt0++;
            if (e1) cnt1++;
        end
`ifdef ALU_ARB_STATS_EN
        if (stats_clr_i) begin
            cnt0 = 0;
            cnt1 = 0;
        end
`endif
        case (mode)
            0: if (drain_i) mode = 1;
            1: if (q.size() == 0 && !p) mode = 2;
            default: if (!drain_i) mode = 0;
        endcase
        g0 = e0;
        g1 = e1;
        cyc_n++;
        #1;
    endtask

    // New operands only once the previous ones were accepted (or not offered).
    task automatic rnd_req(input int pct);
        if (!req0_valid_i || g0) begin
            req0_valid_i = ($urandom_range(99) < pct);
            req0_op1_i = 8'($urandom);
            req0_op2_i = 8'($urandom);
        end
        if (!req1_valid_i || g1) begin
            req1_valid_i = ($urandom_range(99) < pct);
            req1_op1_i = 8'($urandom);
            req1_op2_i = 8'($urandom);
        end
    endtask

    task automatic idle_steps(input int n);
        req0_valid_i = 0;
        req1_valid_i = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk("rst_rsp0", rsp0_valid_o, 0);
        chk("rst_rsp1", rsp1_valid_o, 0);
        chk("rst_data", rsp_data_o, 0);
        chk("rst_idle", idle_o, 0);
        chk("rst_inflight", inflight_o, 0);
        rst = 0;
        model_reset();

        // Single op: 5 + 3
        req0_valid_i = 1;
        req0_op1_i = 8'd5;
        req0_op2_i = 8'd3;
        step();
        idle_steps(6);

        // Contention: both valid for 6 cycles
        req0_valid_i = 1;
        req1_valid_i = 1;
        g0 = 0;
        g1 = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("contention_inflight_max", inflight_o <= IW'(LAT + 1), 1);
            if (g0) begin
                req0_op1_i = 8'($urandom);
                req0_op2_i = 8'($urandom);
            end
            if (g1) begin
                req1_op1_i = 8'($urandom);
                req1_op2_i = 8'($urandom);
            end
        end
        idle_steps(6);

        // Lone requester 1
        req1_valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            req1_op1_i = 8'($urandom);
            req1_op2_i = 8'($urandom);
            step();
        end
        idle_steps(6);

        // Drain with requester 0 still valid
        req0_valid_i = 1;
        for (int i = 0; i < 2; i++) begin
            req0_op1_i = 8'($urandom);
            req0_op2_i = 8'($urandom);
            step();
        end
        drain_i = 1;
        begin
            int k;
            k = 0;
            while (mode != 2 && k < 20) begin
                step();
                k++;
            end
            if (k == 20) begin
                errors++;
                $display("FAIL drain_timeout observed=not idle expected=idle");
            end
        end
        step();
        step();
        drain_i = 0;
        step();
        step();
        idle_steps(6);

        // Drain while already empty
        drain_i = 1;
        step();
        step();
        step();
        drain_i = 0;
        idle_steps(2);

        // Randomized traffic with occasional drain requests
        g0 = 0;
        g1 = 0;
        for (int i = 0; i < 300; i++) begin
            rnd_req(70);
            drain_i = ($urandom_range(31) == 0) ? 1'b1 : (mode == 2 ? 1'b0 : drain_i);
            if (mode == 1 && $urandom_range(3) == 0) drain_i = 0;
            step();
        end
        drain_i = 0;
        idle_steps(8);

        // Reset mid-flight
        req0_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            req0_op1_i = 8'($urandom);
            req0_op2_i = 8'($urandom);
            step();
        end
        req1_valid_i = 1;
        #2;
        rst = 1;
        #1;
        chk("midrst_rsp0", rsp0_valid_o, 0);
        chk("midrst_rsp1", rsp1_valid_o, 0);
        chk("midrst_inflight", inflight_o, 0);
        chk("midrst_ready0", req0_ready_o, 0);
        chk("midrst_ready1", req1_ready_o, 0);
        chk("midrst_data", rsp_data_o, 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        step();
        idle_steps(8);

`ifdef ALU_ARB_STATS_EN
        // Grant counters: 10 to req0, 7 to req1
        stats_clr_i = 1;
        step();
        stats_clr_i = 0;
        req0_valid_i = 1;
        for (int i = 0; i < 10; i++) step();
        req0_valid_i = 0;
        req1_valid_i = 1;
        for (int i = 0; i < 7; i++) step();
        idle_steps(5);
        chk("stats_cnt0_10", grant_cnt0_o, 10);
        chk("stats_cnt1_7", grant_cnt1_o, 7);
        req0_valid_i = 1;
        stats_clr_i = 1;
        step();
        stats_clr_i = 0;
        idle_steps(5);
        chk("stats_clr_cnt0", grant_cnt0_o, 0);
        chk("stats_clr_cnt1", grant_cnt1_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
